// File: rtl/usb_tx_arbiter.sv
// rtl/usb_tx_arbiter.sv - two-source whole-packet TX arbiter with bus-turnaround gap
module usb_tx_arbiter #(
    parameter int TURNAROUND = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       usb_reset,
    input  logic       rx_active,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       valid0,
    input  logic       valid1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       last0,
    input  logic       last1,
    output logic       ready0,
    output logic       ready1,
    output logic [1:0] grant,
    output logic       tx_abort
);

    localparam int GW = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(TURNAROUND);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic [GW-1:0] gap;
    logic          sel_valid;
    logic          sel_last;
    logic          accept;
    logic          underrun;
    logic          pkt_end;

    always_comb begin
        sel_valid = (grant[0] & valid0) | (grant[1] & valid1);
        sel_last  = (grant[0] & last0)  | (grant[1] & last1);
        accept    = (state == SEND) & tx_ready & sel_valid;
        underrun  = (state == SEND) & tx_ready & ~sel_valid;
        pkt_end   = (accept & sel_last) | underrun;
        tx_data   = 8'h00;
        if (grant[0]) begin
            tx_data = data0;
        end else if (grant[1]) begin
            tx_data = data1;
        end
    end

    assign ready0   = accept & grant[0];
    assign ready1   = accept & grant[1];
    assign tx_abort = underrun;

    always_ff @(posedge clk) begin
        if (reset || usb_reset) begin
            state    <= IDLE;
            grant    <= 2'b00;
            tx_valid <= 1'b0;
            gap      <= '0;
        end else begin
            // Receive activity keeps the gap pinned at full length, even mid-packet.
            if (rx_active || pkt_end) begin
                gap <= GAP_LOAD;
            end else if (gap != '0) begin
                gap <= gap - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (gap == '0 && !rx_active && (valid0 || valid1)) begin
                        state    <= SEND;
                        tx_valid <= 1'b1;
                        grant    <= valid0 ? 2'b01 : 2'b10;
                    end
                end
                SEND: begin
                    if (pkt_end) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        grant    <= 2'b00;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    grant    <= 2'b00;
                end
            endcase
        end
    end

endmodule
